sdp_fifo_sync: RTL and testbench
================================

Name: sdp_fifo_sync

Overview:
- Parametrised single-clock FIFO built on an inferred simple-dual-port block RAM.
- Successor to the fixed 2Kx16 two-clock SDP RAM wrapper: generic width and depth, valid/ready handshakes, first-word-fall-through output and occupancy flags.
- Used to buffer camera pixel/line data between the capture path and downstream consumers such as PSRAM writers and LCD output.

Parameters:
- DATA_WIDTH, 16, word width in bits.
- ADDR_WIDTH, 11, RAM address width; DEPTH = 2**ADDR_WIDTH words (2048 by default).
- ALMOST_FULL_LEVEL, 2040, almost_full asserted when level >= this value.
- ALMOST_EMPTY_LEVEL, 8, almost_empty asserted when level <= this value.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous flush, active high.
- wr_valid  in  1  write request.
- wr_data  in  DATA_WIDTH  write word.
- wr_ready  out  1  FIFO can accept a word.
- rd_valid  out  1  rd_data holds a valid word.
- rd_data  out  DATA_WIDTH  head-of-FIFO word (FWFT).
- rd_ready  in  1  consumer accepts rd_data.
- level  out  ADDR_WIDTH+1  words currently held, range 0..DEPTH.
- almost_full  out  1  level >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  level <= ALMOST_EMPTY_LEVEL.

Behaviour:
- Reset (reset_n low, asynchronous): pointers = 0, level = 0, rd_valid = 0, rd_data = 0, wr_ready = 1, almost_full = 0, almost_empty = 1. Release is synchronous to clk.
- Write handshake: a write is accepted on a rising edge where wr_valid && wr_ready. The word goes to RAM[wr_ptr] and wr_ptr increments modulo DEPTH.
- wr_ready is registered and equals (level < DEPTH). It is not relieved combinationally by a same-cycle read, so there is no rd_ready-to-wr_ready path. When full, wr_ready stays 0 even while a read completes.
- Read handshake: a word is consumed on an edge where rd_valid && rd_ready. While rd_valid && !rd_ready, rd_data and rd_valid stay stable.
- RAM read has 1-cycle registered latency. Prefetch logic (output register plus a skid entry as needed) provides FWFT behaviour.
- Fall-through latency: a write accepted at edge t into an empty FIFO gives rd_valid = 1 after edge t+2.
- Throughput: sustained 1 word/clk on both sides when wr_valid and rd_ready are held high. In steady state, level stays constant when writes and reads complete every cycle.
- Level counts every stored word, including words in the RAM, in flight in the read pipeline, and in the output stage.
  - +1 per accepted write, −1 per completed read; no change when both occur in the same cycle.
  - level never exceeds DEPTH and never goes below 0.
- almost_full and almost_empty are registered and derived from the next-state level, so they update on the same edge as level.
- Pointer wrap: wr_ptr and rd_ptr wrap DEPTH−1 → 0 with no data corruption. Ordering is strictly FIFO.
- clear (synchronous) has priority over writes and reads in the same cycle.
  - Pointers, level and rd_valid return to reset values; rd_data is held.
  - A write presented in the clear cycle is discarded. wr_ready is 1 on the next cycle.
- Reset asserted mid-operation discards all contents immediately. RAM contents need not be initialised.
- Write with !wr_ready and read with !rd_valid are legal no-ops: no state change, no flag.

Test Plan:
- Reset values: hold reset_n low 5 clk with random inputs → rd_valid=0, rd_data=0, wr_ready=1, level=0, almost_empty=1, almost_full=0.
- Latency: empty FIFO, write 0x1234 at edge t, rd_ready=1 → rd_valid=1 with rd_data=0x1234 after edge t+2; level 1→0 on consumption.
- Fill and drain: rd_ready=0, write 0..2047.
  - almost_full rises when level reaches 2040; wr_ready=0 at level 2048; an extra write of 0xFFFF is ignored.
  - Then rd_ready=1 → 0..2047 read in order, one per clk; almost_empty rises at level 8; rd_valid=0 after the last word.
- Wrap and streaming: 5000 consecutive words with wr_valid=rd_ready=1 after 100 preloaded words → level constant at 100, output sequence matches input, both pointers wrap twice.
- Backpressure: random rd_ready (50%) and random wr_valid → rd_data stable whenever rd_valid && !rd_ready; scoreboard shows no loss or duplication.
- Clear/reset mid-operation: at level 300, pulse clear with a simultaneous write → next cycle level=0, rd_valid=0, wr_ready=1; a subsequent write 0xABCD is read back as the first word. Repeat using reset_n → same result.

Source files
------------

// File: rtl/sdp_fifo_sync.sv
// -----------------------------------------------------------------------------
// sdp_fifo_sync
//   Single-clock first-word-fall-through FIFO built on an inferred
//   simple-dual-port block RAM. Buffers camera pixel/line data between the
//   capture path and downstream consumers (PSRAM writer, LCD output).
//
//   Read path: RAM (1-cycle registered read) -> output register, with a
//   one-entry skid register that catches a RAM word still in flight when the
//   consumer stalls. Up to two words live downstream of the RAM plus one in
//   flight; the fetch rule below never lets that exceed the two slots.
//
// Ports
//   clk          in   rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   clear        in   synchronous flush (priority over reads and writes)
//   wr_valid     in   write request
//   wr_data      in   write word
//   wr_ready     out  registered, 1 while level < DEPTH
//   rd_valid     out  rd_data holds the head-of-FIFO word
//   rd_data      out  head-of-FIFO word (held when not valid and over clear)
//   rd_ready     in   consumer accepts rd_data
//   level        out  words held: RAM + in flight + skid + output stage
//   almost_full  out  level >= ALMOST_FULL_LEVEL
//   almost_empty out  level <= ALMOST_EMPTY_LEVEL
// -----------------------------------------------------------------------------
module sdp_fifo_sync #(
    parameter int DATA_WIDTH         = 16,
    parameter int ADDR_WIDTH         = 11,
    parameter int ALMOST_FULL_LEVEL  = 2040,
    parameter int ALMOST_EMPTY_LEVEL = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] ZERO_C  = {(ADDR_WIDTH+1){1'b0}};
    localparam logic [ADDR_WIDTH:0] AF_C    = ALMOST_FULL_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AE_C    = ALMOST_EMPTY_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ZERO_C = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO_C = {DATA_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q_r;

    logic [ADDR_WIDTH-1:0] wr_ptr_r;
    logic [ADDR_WIDTH-1:0] rd_ptr_r;
    logic [ADDR_WIDTH:0]   ram_cnt_r;     // words in RAM not yet fetched
    logic [ADDR_WIDTH:0]   level_r;
    logic                  pend_r;        // ram_q_r carries a fetched word
    logic [DATA_WIDTH-1:0] skid_data_r;
    logic                  skid_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic                  out_valid_r;
    logic                  wr_ready_r;
    logic                  almost_full_r;
    logic                  almost_empty_r;

    logic                  wr_fire_s;
    logic                  pop_s;
    logic                  fetch_s;
    logic [1:0]            occ_s;
    logic [ADDR_WIDTH:0]   level_next_s;
    logic [ADDR_WIDTH:0]   ram_cnt_next_s;

    // Handshakes, fetch decision and next-state occupancy counters.
    always_comb begin
        wr_fire_s      = wr_valid && wr_ready_r && !clear;
        pop_s          = out_valid_r && rd_ready;
        occ_s          = {1'b0, out_valid_r} + {1'b0, skid_valid_r} + {1'b0, pend_r};
        // A fetched word must find a free slot (output or skid) when it lands.
        fetch_s        = !clear && (ram_cnt_r != ZERO_C) && (pop_s || (occ_s < 2'd2));
        level_next_s   = level_r;
        ram_cnt_next_s = ram_cnt_r;
        if (clear) begin
            level_next_s   = ZERO_C;
            ram_cnt_next_s = ZERO_C;
        end else begin
            case ({wr_fire_s, pop_s})
                2'b10:   level_next_s = level_r + ONE_C;
                2'b01:   level_next_s = level_r - ONE_C;
                default: level_next_s = level_r;
            endcase
            case ({wr_fire_s, fetch_s})
                2'b10:   ram_cnt_next_s = ram_cnt_r + ONE_C;
                2'b01:   ram_cnt_next_s = ram_cnt_r - ONE_C;
                default: ram_cnt_next_s = ram_cnt_r;
            endcase
        end
    end

    // Block RAM: synchronous write port and registered read port, no reset.
    always_ff @(posedge clk) begin
        if (wr_fire_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
        if (fetch_s) begin
            ram_q_r <= mem_r[rd_ptr_r];
        end
    end

    // Pointers, counters, flags and the FWFT output/skid stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r       <= PTR_ZERO_C;
            rd_ptr_r       <= PTR_ZERO_C;
            ram_cnt_r      <= ZERO_C;
            level_r        <= ZERO_C;
            pend_r         <= 1'b0;
            skid_data_r    <= DATA_ZERO_C;
            skid_valid_r   <= 1'b0;
            out_data_r     <= DATA_ZERO_C;
            out_valid_r    <= 1'b0;
            wr_ready_r     <= 1'b1;
            almost_full_r  <= 1'b0;
            almost_empty_r <= 1'b1;
        end else begin
            level_r        <= level_next_s;
            ram_cnt_r      <= ram_cnt_next_s;
            wr_ready_r     <= (level_next_s < DEPTH_C);
            almost_full_r  <= (level_next_s >= AF_C);
            almost_empty_r <= (level_next_s <= AE_C);
            if (clear) begin
                // rd_data is deliberately held; only validity is dropped.
                wr_ptr_r     <= PTR_ZERO_C;
                rd_ptr_r     <= PTR_ZERO_C;
                pend_r       <= 1'b0;
                skid_valid_r <= 1'b0;
                out_valid_r  <= 1'b0;
            end else begin
                if (wr_fire_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
                end
                if (fetch_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
                end
                pend_r <= fetch_s;
                if (!out_valid_r || pop_s) begin
                    // Output slot frees: skid is older than the in-flight word.
                    if (skid_valid_r) begin
                        out_data_r  <= skid_data_r;
                        out_valid_r <= 1'b1;
                        if (pend_r) begin
                            skid_data_r <= ram_q_r;
                        end else begin
                            skid_valid_r <= 1'b0;
                        end
                    end else if (pend_r) begin
                        out_data_r  <= ram_q_r;
                        out_valid_r <= 1'b1;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                end else if (pend_r) begin
                    // Consumer stalled: park the landing word in the skid.
                    skid_data_r  <= ram_q_r;
                    skid_valid_r <= 1'b1;
                end
            end
        end
    end

    assign wr_ready     = wr_ready_r;
    assign rd_valid     = out_valid_r;
    assign rd_data      = out_data_r;
    assign level        = level_r;
    assign almost_full  = almost_full_r;
    assign almost_empty = almost_empty_r;

endmodule

// File: tb/tb_sdp_fifo_sync.sv
module tb_sdp_fifo_sync;

    localparam int DW    = 16;
    localparam int AW    = 11;
    localparam int DEPTH = 2048;
    localparam int AFL   = 2040;
    localparam int AEL   = 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          clear = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data = 16'h0000;
    logic          wr_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          rd_ready = 1'b0;
    logic [AW:0]   level;
    logic          almost_full;
    logic          almost_empty;

    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] sb_q[$];
    logic          hold_prev = 1'b0;
    logic [DW-1:0] hold_data = 16'h0000;
    int            rd_count = 0;
    logic [DW-1:0] exp_w;

    sdp_fifo_sync #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
        .ALMOST_FULL_LEVEL(AFL), .ALMOST_EMPTY_LEVEL(AEL)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
        .level(level), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: score handshakes seen before the edge, then check state after it.
    task automatic cycle();
        logic wr_fire;
        logic rd_fire;
        wr_fire   = reset_n && !clear && wr_valid && wr_ready;
        rd_fire   = reset_n && !clear && rd_valid && rd_ready;
        if (rd_fire) begin
            rd_count++;
            if (sb_q.size() == 0) begin
                check("rd_unexpected", 32'(rd_data), 32'hDEAD_BEEF);
            end else begin
                exp_w = sb_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(exp_w));
            end
        end
        hold_prev = reset_n && !clear && rd_valid && !rd_ready;
        hold_data = rd_data;
        if (wr_fire) sb_q.push_back(wr_data);
        if (!reset_n || clear) sb_q.delete();
        @(posedge clk);
        #1;
        check("level", 32'(level), 32'(sb_q.size()));
        check("wr_ready", 32'(wr_ready), 32'(sb_q.size() < DEPTH));
        check("almost_full", 32'(almost_full), 32'(sb_q.size() >= AFL));
        check("almost_empty", 32'(almost_empty), 32'(sb_q.size() <= AEL));
        if (sb_q.size() == 0) check("rd_valid_empty", 32'(rd_valid), 32'd0);
        if (hold_prev && reset_n && !clear) begin
            check("hold_valid", 32'(rd_valid), 32'd1);
            check("hold_data", 32'(rd_data), 32'(hold_data));
        end
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n;
        n = 0;
        while (!rd_valid && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(rd_valid), 32'd1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        rd_ready = 1'b1;
        wr_valid = 1'b0;
        n = 0;
        while ((sb_q.size() != 0 || rd_valid) && n < budget) begin
            cycle();
            n++;
        end
        check(tag, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic fill(input int count, input logic [DW-1:0] base);
        rd_ready = 1'b0;
        for (int i = 0; i < count; i++) begin
            wr_valid = 1'b1;
            wr_data  = base + DW'(i);
            cycle();
        end
        wr_valid = 1'b0;
    endtask

    initial begin
        // Reset with random inputs.
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = DW'($urandom);
            rd_ready = 1'($urandom_range(0, 1));
            clear    = 1'($urandom_range(0, 1));
            cycle();
        end
        check("rst_rd_data", 32'(rd_data), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        clear = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
        reset_n = 1'b1;
        cycle();

        // Fall-through latency.
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        cycle();                       // edge t
        wr_valid = 1'b0;
        check("lat_t0_level", 32'(level), 32'd1);
        check("lat_t0_valid", 32'(rd_valid), 32'd0);
        cycle();                       // edge t+1
        check("lat_t1_valid", 32'(rd_valid), 32'd0);
        cycle();                       // edge t+2
        check("lat_t2_valid", 32'(rd_valid), 32'd1);
        check("lat_t2_data", 32'(rd_data), 32'h1234);
        cycle();                       // consumed
        check("lat_consumed_level", 32'(level), 32'd0);

        // Fill to full, extra write ignored, drain in order.
        fill(DEPTH, 16'h0000);
        check("full_level", 32'(level), 32'd2048);
        check("full_wr_ready", 32'(wr_ready), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        cycle();
        wr_valid = 1'b0;
        check("full_extra_level", 32'(level), 32'd2048);
        rd_count = 0;
        drain("fill_drain", 2200);
        check("fill_drain_count", 32'(rd_count), 32'd2048);
        check("drain_rd_valid", 32'(rd_valid), 32'd0);

        // Streaming across pointer wraps with constant level.
        fill(100, 16'h4000);
        wait_valid("pre_valid", 10);
        rd_count = 0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            wr_data = 16'h8000 + DW'(i);
            cycle();
        end
        check("stream_count", 32'(rd_count), 32'd5000);
        check("stream_level", 32'(level), 32'd100);
        drain("stream_drain", 300);

        // Random backpressure.
        for (int i = 0; i < 3000; i++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = DW'($urandom);
            rd_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        drain("bp_drain", 4000);

        // Clear at level 300 with a simultaneous write.
        fill(300, 16'h2000);
        check("pre_clear_level", 32'(level), 32'd300);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'h5555;
        cycle();
        clear    = 1'b0;
        wr_valid = 1'b0;
        check("clear_level", 32'(level), 32'd0);
        check("clear_rd_valid", 32'(rd_valid), 32'd0);
        check("clear_wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 16'hABCD;
        cycle();
        wr_valid = 1'b0;
        wait_valid("clear_valid", 10);
        check("clear_first", 32'(rd_data), 32'hABCD);
        drain("clear_drain", 20);

        // Same sequence using asynchronous reset.
        fill(300, 16'h3000);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_level", 32'(level), 32'd0);
        check("async_rst_valid", 32'(rd_valid), 32'd0);
        wr_valid = 1'b1;
        wr_data  = 16'h6666;
        cycle();
        reset_n  = 1'b1;
        wr_valid = 1'b0;
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = 16'hABCD;
        cycle();
        wr_valid = 1'b0;
        wait_valid("rst_valid", 10);
        check("rst_first", 32'(rd_data), 32'hABCD);
        drain("rst_drain", 20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
